// File: rtl/gray_rx_check_if.sv
// Bus between the Gray-code source and the gray_rx_check monitor: sample in, decoded status out.
interface gray_rx_check_if #(
    parameter int unsigned CBITS = 16,
    parameter int unsigned WBITS = 8
);
    logic [CBITS-1:0] gray_in;
    logic             gray_vld;
    logic [CBITS-1:0] bin_out;
    logic             locked;
    logic             step_ok;
    logic             wrap;
    logic [WBITS-1:0] wrap_cnt;
    logic             err;

    modport master (
        output gray_in, gray_vld,
        input  bin_out, locked, step_ok, wrap, wrap_cnt, err
    );

    modport slave (
        input  gray_in, gray_vld,
        output bin_out, locked, step_ok, wrap, wrap_cnt, err
    );
endinterface

// File: rtl/gray_rx_check.sv
// Gray-code stream checker: decodes samples, verifies +1 single-bit steps, counts wraps.
// Optional macro GRAY_CHK_HOLD_EN: a repeated sample while locked is a legal stall.
module gray_rx_check #(
    parameter int unsigned CBITS = 16,
    parameter int unsigned WBITS = 8
) (
    input logic             clk,
    input logic             rst,
    gray_rx_check_if.slave  bus
);

    typedef enum logic [1:0] {StEmpty, StLock, StFault} state_e;

`ifdef GRAY_CHK_HOLD_EN
    localparam bit HoldEn = 1'b1;
`else
    localparam bit HoldEn = 1'b0;
`endif

    localparam logic [CBITS-1:0] COne = CBITS'(1);
    localparam logic [WBITS-1:0] WOne = WBITS'(1);

    state_e           state_q, state_d;
    logic [CBITS-1:0] prev_gray_q, prev_gray_d;
    logic [CBITS-1:0] prev_bin_q, prev_bin_d;
    logic             step_ok_q, step_ok_d;
    logic             wrap_q, wrap_d;
    logic [WBITS-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             err_q, err_d;

    logic [CBITS-1:0] nb;
    logic [CBITS-1:0] diff;
    logic             one_bit;
    logic             hold;
    logic             legal;

    // Prefix-XOR from the MSB: bin[i] is the parity of gray[CBITS-1:i].
    always_comb begin
        nb = '0;
        for (int i = 0; i < CBITS; i++) begin
            nb[i] = ^(bus.gray_in >> i);
        end
    end

    always_comb begin
        diff    = bus.gray_in ^ prev_gray_q;
        one_bit = (diff != '0) && ((diff & (diff - COne)) == '0);
        hold    = (diff == '0);
        legal   = one_bit && (nb == prev_bin_q + COne);
    end

    always_comb begin
        state_d     = state_q;
        prev_gray_d = prev_gray_q;
        prev_bin_d  = prev_bin_q;
        step_ok_d   = 1'b0;
        wrap_d      = 1'b0;
        wrap_cnt_d  = wrap_cnt_q;
        err_d       = err_q;
        if (bus.gray_vld) begin
            unique case (state_q)
                StEmpty: begin
                    prev_gray_d = bus.gray_in;
                    prev_bin_d  = nb;
                    state_d     = StLock;
                end
                StLock: begin
                    if (legal) begin
                        step_ok_d   = 1'b1;
                        prev_gray_d = bus.gray_in;
                        prev_bin_d  = nb;
                        if (&prev_bin_q) begin
                            wrap_d = 1'b1;
                            if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WOne;
                        end
                    end else if (!(HoldEn && hold)) begin
                        err_d       = 1'b1;
                        state_d     = StFault;
                        prev_gray_d = bus.gray_in;
                        prev_bin_d  = nb;
                    end
                end
                StFault: begin
                    prev_gray_d = bus.gray_in;
                    prev_bin_d  = nb;
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            prev_gray_q <= '0;
            prev_bin_q  <= '0;
            step_ok_q   <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_gray_q <= prev_gray_d;
            prev_bin_q  <= prev_bin_d;
            step_ok_q   <= step_ok_d;
            wrap_q      <= wrap_d;
            wrap_cnt_q  <= wrap_cnt_d;
            err_q       <= err_d;
        end
    end

    // bin_out always mirrors the last accepted sample, which is exactly prev_bin.
    assign bus.bin_out  = prev_bin_q;
    assign bus.locked   = (state_q != StEmpty);
    assign bus.step_ok  = step_ok_q;
    assign bus.wrap     = wrap_q;
    assign bus.wrap_cnt = wrap_cnt_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_gray_rx_check.sv
// Directed plus random stimulus for gray_rx_check (CBITS=4, WBITS=2) against a value-level model.
module tb_gray_rx_check;

`ifdef GRAY_CHK_HOLD_EN
    localparam bit HoldEn = 1'b1;
`else
    localparam bit HoldEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gray_rx_check_if #(.CBITS(4), .WBITS(2)) bus ();

    gray_rx_check #(.CBITS(4), .WBITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: plain integers describing what the stream has meant so far.
    int m_have, m_fault, m_prev_bin, m_prev_gray, m_step, m_wrap, m_wc, m_err;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int from_gray(input int g);
        for (int b = 0; b < 16; b++) begin
            if (to_gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int g);
        int nb;
        m_step = 0;
        m_wrap = 0;
        if (r) begin
            m_have = 0; m_fault = 0; m_prev_bin = 0; m_prev_gray = 0; m_wc = 0; m_err = 0;
        end else if (v) begin
            nb = from_gray(g);
            if (m_have == 0) begin
                m_have = 1; m_prev_bin = nb; m_prev_gray = g;
            end else if (m_fault != 0) begin
                m_prev_bin = nb; m_prev_gray = g;
            end else if (nb == (m_prev_bin + 1) % 16) begin
                m_step = 1;
                if (nb == 0) begin
                    m_wrap = 1;
                    if (m_wc < 3) m_wc++;
                end
                m_prev_bin = nb; m_prev_gray = g;
            end else if (!(HoldEn && g == m_prev_gray)) begin
                m_fault = 1; m_err = 1; m_prev_bin = nb; m_prev_gray = g;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int g);
        @(negedge clk);
        rst          = r;
        bus.gray_vld = v;
        bus.gray_in  = 4'(g);
        @(posedge clk);
        model_step(r, v, g);
        #1;
        check("bin_out",  32'(bus.bin_out),  32'(m_prev_bin));
        check("locked",   32'(bus.locked),   32'(m_have));
        check("step_ok",  32'(bus.step_ok),  32'(m_step));
        check("wrap",     32'(bus.wrap),     32'(m_wrap));
        check("wrap_cnt", 32'(bus.wrap_cnt), 32'(m_wc));
        check("err",      32'(bus.err),      32'(m_err));
    endtask

    task automatic feed_bin(input int b);
        cycle(1'b0, 1'b1, to_gray(b % 16));
    endtask

    initial begin
        bit r, v;
        int g, pick;
        rst          = 1'b1;
        bus.gray_vld = 1'b0;
        bus.gray_in  = '0;
        model_step(1'b1, 1'b0, 0);

        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 5);

        // First four Gray words, then on to the first wrap.
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 1);
        cycle(1'b0, 1'b1, 3);
        cycle(1'b0, 1'b1, 2);
        check("bin_after_0132", 32'(bus.bin_out), 32'd3);
        for (int b = 4; b <= 16; b++) feed_bin(b);
        check("first_wrap_cnt", 32'(bus.wrap_cnt), 32'd1);
        cycle(1'b0, 1'b0, 9);
        for (int b = 1; b <= 64; b++) feed_bin(b);
        check("wrap_cnt_sat", 32'(bus.wrap_cnt), 32'd3);
        check("wrap_at_sat", 32'(bus.wrap), 32'd1);

        // Backward step.
        cycle(1'b1, 1'b0, 0);
        feed_bin(0); feed_bin(1); feed_bin(2);
        cycle(1'b0, 1'b1, 1);
        check("err_backward", 32'(bus.err), 32'd1);
        for (int b = 2; b <= 6; b++) feed_bin(b);

        // Two bits changed.
        cycle(1'b1, 1'b0, 0);
        feed_bin(0); feed_bin(1); feed_bin(2);
        cycle(1'b0, 1'b1, 5);
        check("err_two_bits", 32'(bus.err), 32'd1);
        check("bin_two_bits", 32'(bus.bin_out), 32'd6);

        // Repeat, then make sure FAULT is reached, then reset with a live sample.
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 3);
        cycle(1'b0, 1'b1, 2);
        cycle(1'b0, 1'b1, 2);
        check("err_hold", 32'(bus.err), HoldEn ? 32'd0 : 32'd1);
        cycle(1'b0, 1'b1, 5);
        cycle(1'b1, 1'b1, 5);
        cycle(1'b0, 1'b1, 7);
        check("ref_after_rst", 32'(bus.bin_out), 32'd5);
        check("err_after_rst", 32'(bus.err), 32'd0);

        // Random walk: mostly legal steps, occasional holds, jumps, gaps and resets.
        for (int n = 0; n < 600; n++) begin
            r    = (m_fault != 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
            v    = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 19);
            if (pick == 0)      g = $urandom_range(0, 15);
            else if (pick == 1) g = m_prev_gray;
            else                g = to_gray((m_prev_bin + 1) % 16);
            cycle(r, v, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
